// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared constants and types for the data-RAM arbiter (mem_arbiter and its
//   winner-select sub-module mem_arb_pick).
//   - FSM state codes (2-bit, legacy-compatible localparams)
//   - requester ids (m0 = LSU data port, m1 = secondary master)
//   - the latched command record
//   Configuration macro used by the arbiter: MEM_ARB_RR_EN (see mem_arb_pick).
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // FSM state codes
    localparam logic [1:0] MEM_ARB_IDLE  = 2'd0;
    localparam logic [1:0] MEM_ARB_ISSUE = 2'd1;
    localparam logic [1:0] MEM_ARB_WAIT  = 2'd2;
    localparam logic [1:0] MEM_ARB_RESP  = 2'd3;

    // Requester ids
    localparam logic MEM_ARB_M0 = 1'b0;
    localparam logic MEM_ARB_M1 = 1'b1;

    // Idle values driven onto the RAM and response buses
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        CHIP_DISABLE  = 1'b0;

    // Command captured at grant time; the requester's inputs are not looked
    // at again until the next grant.
    typedef struct packed {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } mem_arb_cmd_t;

    localparam mem_arb_cmd_t CMD_RESET = '{
        id:    MEM_ARB_M0,
        we:    WRITE_DISABLE,
        addr:  ZERO_WORD,
        sel:   4'h0,
        wdata: ZERO_WORD
    };

endpackage

// File: rtl/mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner select for the data-RAM arbiter.
//   Configuration macro: MEM_ARB_RR_EN
//     undefined : fixed priority, m0 wins every tie (m1 may starve).
//     defined   : round-robin, a tie goes to the requester that did not win
//                 last time.
//   A lone requester always wins. The output is only meaningful while at
//   least one request is high.
// Ports
//   m0_req_i      in   1  LSU request
//   m1_req_i      in   1  secondary master request
//   last_grant_i  in   1  id of the most recent winner
//   grant_o       out  1  id of the winner
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic m0_req_i,
    input  logic m1_req_i,
    input  logic last_grant_i,
    output logic grant_o
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        if (m0_req_i && m1_req_i) begin
            grant_o = (last_grant_i == MEM_ARB_M0) ? MEM_ARB_M1 : MEM_ARB_M0;
        end else if (m1_req_i) begin
            grant_o = MEM_ARB_M1;
        end else begin
            grant_o = MEM_ARB_M0;
        end
    end
`else
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_o = (m1_req_i && !m0_req_i) ? MEM_ARB_M1 : MEM_ARB_M0;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port data RAM between the LSU data port (m0) and a
//   secondary master (m1, DMA/debug loader). A granted command is latched,
//   driven onto the RAM for exactly one cycle, and completed with a one-cycle
//   ack (read data is returned RD_LAT cycles after the RAM strobe).
//   FSM: IDLE -> ISSUE -> (read: WAIT) -> RESP -> IDLE.
//   Tie-break policy is selected by macro MEM_ARB_RR_EN inside mem_arb_pick.
// Parameters
//   RD_LAT        RAM read latency in cycles after ram_ce_o (legal 1..4)
// Ports
//   clk_i         in   1   clock, rising edge
//   rst_i         in   1   synchronous active-high reset
//   m0_req_i      in   1   LSU request, level, held until ack
//   m0_we_i       in   1   1 = write, 0 = read
//   m0_addr_i     in   32  byte address
//   m0_sel_i      in   4   byte enables
//   m0_wdata_i    in   32  write data
//   m0_rdata_o    out  32  read data, valid while m0_ack_o
//   m0_ack_o      out  1   one-cycle completion pulse
//   m0_stall_o    out  1   m0_req_i & ~m0_ack_o (pipeline stall request)
//   m1_*          same meaning as m0_* (no stall output)
//   ram_ce_o      out  1   RAM strobe, one cycle per transaction
//   ram_we_o/ram_addr_o/ram_sel_o/ram_wdata_o  out  1/32/4/32  RAM command
//   ram_rdata_i   in   32  RAM read data, valid RD_LAT cycles after ram_ce_o
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,
    output logic        m0_stall_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    // The WAIT counter starts at RD_LAT-1 so that the capture happens in the
    // cycle where ram_rdata_i is valid (RD_LAT cycles after the strobe).
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    logic [1:0]   state_q, state_d;
    mem_arb_cmd_t cmd_q, cmd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         last_grant_q, last_grant_d;

    logic         any_req;
    logic         pick_id;

    assign any_req = m0_req_i | m1_req_i;

    mem_arb_pick u_pick (
        .m0_req_i     (m0_req_i),
        .m1_req_i     (m1_req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_id)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;

        case (state_q)
            MEM_ARB_IDLE: begin
                if (any_req) begin
                    cmd_d.id     = pick_id;
                    cmd_d.we     = (pick_id == MEM_ARB_M1) ? m1_we_i    : m0_we_i;
                    cmd_d.addr   = (pick_id == MEM_ARB_M1) ? m1_addr_i  : m0_addr_i;
                    cmd_d.sel    = (pick_id == MEM_ARB_M1) ? m1_sel_i   : m0_sel_i;
                    cmd_d.wdata  = (pick_id == MEM_ARB_M1) ? m1_wdata_i : m0_wdata_i;
                    last_grant_d = pick_id;
                    state_d      = MEM_ARB_ISSUE;
                end
            end

            MEM_ARB_ISSUE: begin
                if (cmd_q.we) begin
                    state_d = MEM_ARB_RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = MEM_ARB_WAIT;
                end
            end

            MEM_ARB_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = ram_rdata_i;
                    state_d = MEM_ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            MEM_ARB_RESP: begin
                state_d = MEM_ARB_IDLE;
            end

            default: begin
                state_d = MEM_ARB_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only; reset is
    // synchronous, so rst_i is just another input sampled on the clock edge.
    // A reset mid-transaction drops it without ever reaching RESP, so the
    // aborted transaction never produces an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= MEM_ARB_IDLE;
            cmd_q        <= CMD_RESET;
            cnt_q        <= 2'd0;
            rdata_q      <= ZERO_WORD;
            last_grant_q <= MEM_ARB_M1;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output muxing: the RAM bus is quiet outside ISSUE, responses only in RESP
    // -----------------------------------------------------------------------
    logic in_issue;
    logic in_resp;

    assign in_issue = (state_q == MEM_ARB_ISSUE);
    assign in_resp  = (state_q == MEM_ARB_RESP);

    assign ram_ce_o    = in_issue ? 1'b1        : CHIP_DISABLE;
    assign ram_we_o    = in_issue ? cmd_q.we    : WRITE_DISABLE;
    assign ram_addr_o  = in_issue ? cmd_q.addr  : ZERO_WORD;
    assign ram_sel_o   = in_issue ? cmd_q.sel   : 4'h0;
    assign ram_wdata_o = in_issue ? cmd_q.wdata : ZERO_WORD;

    assign m0_ack_o = in_resp && (cmd_q.id == MEM_ARB_M0);
    assign m1_ack_o = in_resp && (cmd_q.id == MEM_ARB_M1);

    // Writes return zero; rdata_q may still hold an older read result.
    assign m0_rdata_o = (m0_ack_o && !cmd_q.we) ? rdata_q : ZERO_WORD;
    assign m1_rdata_o = (m1_ack_o && !cmd_q.we) ? rdata_q : ZERO_WORD;

    // Drops in the ack cycle so the pipeline advances exactly then.
    assign m0_stall_o = m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (RD_LAT = 3). A behavioural RAM
//   answers the DUT; a transaction-level model predicts, for every cycle,
//   the RAM strobe, acks, read data and stall from the grant timing rules.
//   Directed scenarios pin the model with literal values, followed by a
//   randomized traffic phase. Honours MEM_ARB_RR_EN for the tie-break rule.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int RD_LAT = 3;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        m0_req_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_rdata_o;
    logic        m0_ack_o, m0_stall_o;
    logic        m1_req_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_wdata_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_rdata_o;
    logic        m1_ack_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_rdata_i;

    mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_sel_i    (m0_sel_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rdata_o  (m0_rdata_o),
        .m0_ack_o    (m0_ack_o),
        .m0_stall_o  (m0_stall_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_sel_i    (m1_sel_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rdata_o  (m1_rdata_o),
        .m1_ack_o    (m1_ack_o),
        .ram_ce_o    (ram_ce_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_sel_o   (ram_sel_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit model_on = 1'b0;

    always @(posedge clk) begin
        cyc++;
        model_on = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] def_word(input logic [29:0] key);
        return ({key, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Behavioural RAM: data appears RD_LAT cycles after the strobe, garbage
    // otherwise, so a mistimed capture is visible.
    // -----------------------------------------------------------------------
    logic [31:0] ram_mem [logic [29:0]];
    int          pend_cnt  = -1;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] ram_rd(input logic [29:0] key);
        return ram_mem.exists(key) ? ram_mem[key] : def_word(key);
    endfunction

    initial ram_rdata_i = '0;

    always @(negedge clk) begin
        if (pend_cnt > 0) pend_cnt--;
        if (pend_cnt == 0) begin
            ram_rdata_i = pend_data;
            pend_cnt    = -1;
        end else begin
            ram_rdata_i = $urandom;
        end
        if (ram_ce_o === 1'b1) begin
            if (ram_we_o) begin
                ram_mem[ram_addr_o[31:2]] = merge(ram_rd(ram_addr_o[31:2]), ram_wdata_o, ram_sel_o);
            end else begin
                pend_cnt  = RD_LAT;
                pend_data = ram_rd(ram_addr_o[31:2]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model: one transaction at a time, scheduled by cycle number.
    // Granted in idle cycle t -> strobe at t+1, ack at t+2 (write) or
    // t+2+RD_LAT (read); the cycle after the ack is idle again.
    // -----------------------------------------------------------------------
    logic [31:0] ref_mem [logic [29:0]];
    bit          busy    = 1'b0;
    bit          last_m1 = 1'b1;
    int          t_ce, t_ack;
    bit          tx_id, tx_we;
    logic [31:0] tx_addr, tx_wdata, tx_rdata;
    logic [3:0]  tx_sel;

    function automatic logic [31:0] ref_rd(input logic [29:0] key);
        return ref_mem.exists(key) ? ref_mem[key] : def_word(key);
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            logic        e_ce, e_we, e_ack0, e_ack1;
            logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
            logic [3:0]  e_sel;
            e_ce = 0; e_we = 0; e_addr = 0; e_sel = 0; e_wdata = 0;
            e_ack0 = 0; e_ack1 = 0; e_rd0 = 0; e_rd1 = 0;
            if (busy && cyc == t_ce) begin
                e_ce = 1; e_we = tx_we; e_addr = tx_addr; e_sel = tx_sel; e_wdata = tx_wdata;
            end
            if (busy && cyc == t_ack) begin
                if (tx_id) begin
                    e_ack1 = 1; e_rd1 = tx_we ? 32'h0 : tx_rdata;
                end else begin
                    e_ack0 = 1; e_rd0 = tx_we ? 32'h0 : tx_rdata;
                end
            end
            check("ram_ce",    ram_ce_o,    e_ce);
            check("ram_we",    ram_we_o,    e_we);
            check("ram_addr",  ram_addr_o,  e_addr);
            check("ram_sel",   ram_sel_o,   e_sel);
            check("ram_wdata", ram_wdata_o, e_wdata);
            check("m0_ack",    m0_ack_o,    e_ack0);
            check("m1_ack",    m1_ack_o,    e_ack1);
            check("m0_rdata",  m0_rdata_o,  e_rd0);
            check("m1_rdata",  m1_rdata_o,  e_rd1);
            check("m0_stall",  m0_stall_o,  m0_req_i & ~e_ack0);

            // Advance to the next cycle using this cycle's inputs.
            if (rst_i) begin
                busy    = 1'b0;
                last_m1 = 1'b1;
            end else if (!busy) begin
                if (m0_req_i || m1_req_i) begin
                    if (m0_req_i && m1_req_i) tx_id = RR_MODE ? !last_m1 : 1'b0;
                    else                      tx_id = m1_req_i;
                    tx_we    = tx_id ? m1_we_i    : m0_we_i;
                    tx_addr  = tx_id ? m1_addr_i  : m0_addr_i;
                    tx_sel   = tx_id ? m1_sel_i   : m0_sel_i;
                    tx_wdata = tx_id ? m1_wdata_i : m0_wdata_i;
                    t_ce     = cyc + 1;
                    t_ack    = tx_we ? cyc + 2 : cyc + 2 + RD_LAT;
                    if (tx_we) ref_mem[tx_addr[31:2]] = merge(ref_rd(tx_addr[31:2]), tx_wdata, tx_sel);
                    else       tx_rdata = ref_rd(tx_addr[31:2]);
                    last_m1  = tx_id;
                    busy     = 1'b1;
                end
            end else if (cyc == t_ack) begin
                busy = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus: drive 2 time units after the rising edge, sample on the
    // falling edge.
    // -----------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
        m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_sel_i = sel; m0_wdata_i = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
        m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_sel_i = sel; m1_wdata_i = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order[$];
        int n_ack, n_ce, ack_at;
        bit pend0, pend1, a0, a1;

        // ---- 1: reset held 2 cycles with both requests high ----
        rst_i = 1'b1;
        set_m0(1, 1, 32'h40, 4'hF, 32'h1111_1111);
        set_m1(1, 1, 32'h44, 4'hF, 32'h2222_2222);
        repeat (2) begin
            next_cycle();
            sample();
            check("rst ram_ce", ram_ce_o, 1'b0);
            check("rst ack",    {m0_ack_o, m1_ack_o}, 2'b00);
            check("rst ram_addr", ram_addr_o, 32'h0);
        end
        next_cycle();
        rst_i = 1'b0;
        sample();
        check("post-rst idle ce", ram_ce_o, 1'b0);
        next_cycle();
        sample();
        check("post-rst first ce", ram_ce_o, 1'b1);
        check("post-rst winner addr", ram_addr_o, 32'h40);
        next_cycle();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        sample();
        check("post-rst m0 ack", m0_ack_o, 1'b1);
        repeat (3) next_cycle();

        // ---- 2: m0 write ----
        set_m0(1, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        sample();
        check("wr stall t", m0_stall_o, 1'b1);
        check("wr ce t", ram_ce_o, 1'b0);
        next_cycle();
        sample();
        check("wr ce t+1", ram_ce_o, 1'b1);
        check("wr we t+1", ram_we_o, 1'b1);
        check("wr addr t+1", ram_addr_o, 32'h100);
        check("wr sel t+1", ram_sel_o, 4'b1111);
        check("wr data t+1", ram_wdata_o, 32'hDEAD_BEEF);
        check("wr stall t+1", m0_stall_o, 1'b1);
        next_cycle();
        sample();
        check("wr ack t+2", m0_ack_o, 1'b1);
        check("wr stall t+2", m0_stall_o, 1'b0);
        next_cycle();
        set_m0(0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        // ---- 3: m1 read with RD_LAT=3 ----
        ram_mem[32'h104 >> 2] = 32'h1234_5678;
        ref_mem[32'h104 >> 2] = 32'h1234_5678;
        set_m1(1, 0, 32'h104, 4'hF, 32'h0);
        for (int i = 0; i <= 5; i++) begin
            sample();
            check("rd m1_ack timing", m1_ack_o, (i == 5));
            check("rd m0_ack quiet", m0_ack_o, 1'b0);
            if (i == 5) check("rd m1_rdata", m1_rdata_o, 32'h1234_5678);
            next_cycle();
        end
        set_m1(0, 0, 0, 0, 0);
        next_cycle();

        // ---- 4: both requesting for 4 transactions ----
        set_m0(1, 1, 32'h180, 4'hF, 32'hA0A0_A0A0);
        set_m1(1, 1, 32'h184, 4'hF, 32'hB1B1_B1B1);
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            sample();
            if (m0_ack_o) order.push_back(0);
            if (m1_ack_o) order.push_back(1);
            next_cycle();
        end
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        check("tie ack count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            check("tie order", order[i], RR_MODE ? (i % 2) : 0);
        repeat (2) next_cycle();

        // ---- 5: reset during WAIT of an m0 read ----
        set_m0(1, 0, 32'h100, 4'hF, 32'h0);
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        set_m0(0, 0, 0, 0, 0);
        next_cycle();
        rst_i = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i == 0) check("abort ce", ram_ce_o, 1'b0);
            n_ack += m0_ack_o;
            next_cycle();
        end
        check("abort no m0 ack", n_ack, 0);
        set_m1(1, 1, 32'h1C0, 4'b0101, 32'hCAFE_F00D);
        ack_at = -1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (m1_ack_o && ack_at < 0) ack_at = i;
            if (ack_at >= 0) set_m1(0, 0, 0, 0, 0);
            next_cycle();
        end
        set_m1(0, 0, 0, 0, 0);
        check("after-abort m1 write ack cycle", ack_at, 2);
        next_cycle();

        // ---- 6: m0 drops req during WAIT ----
        set_m0(1, 0, 32'h1C0, 4'hF, 32'h0);
        n_ack = 0; n_ce = 0; ack_at = -1;
        for (int i = 0; i < 10; i++) begin
            sample();
            n_ce += ram_ce_o;
            if (m0_ack_o) begin
                n_ack++;
                ack_at = i;
                check("drop rdata", m0_rdata_o, merge(def_word(30'h1C0 >> 2), 32'hCAFE_F00D, 4'b0101));
            end
            next_cycle();
            if (i == 2) set_m0(0, 0, 0, 0, 0);
        end
        check("drop ce count", n_ce, 1);
        check("drop ack count", n_ack, 1);
        check("drop ack cycle", ack_at, 2 + RD_LAT);

        // ---- random traffic ----
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 3000; c++) begin
            sample();
            a0 = m0_ack_o;
            a1 = m1_ack_o;
            next_cycle();
            rst_i = ($urandom_range(0, 499) == 0);
            if (pend0 && (a0 || $urandom_range(0, 99) < 3)) begin
                m0_req_i = 0; pend0 = 0;
            end else if (!pend0 && $urandom_range(0, 99) < 40) begin
                set_m0(1, 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 15) * 4),
                       4'($urandom), $urandom);
                pend0 = 1;
            end
            if (pend1 && (a1 || $urandom_range(0, 99) < 3)) begin
                m1_req_i = 0; pend1 = 0;
            end else if (!pend1 && $urandom_range(0, 99) < 40) begin
                set_m1(1, 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 15) * 4),
                       4'($urandom), $urandom);
                pend1 = 1;
            end
        end
        rst_i = 0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        repeat (10) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
